// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for a registered-read data RAM.
// Converts a byte-addressed request into RAM word address, lane selects,
// replicated store data and extend type; stalls loads for the RAM read
// latency and keeps load/store/misalign event counters.
module mem_access_unit #(
  parameter int ADDR_BITS = 12,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_en,
  input  logic                 mem_we,
  input  logic [1:0]           mem_size,
  input  logic                 mem_signed,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_done,
  output logic                 mem_stall,
  output logic                 misalign,
  output logic                 ram_rw,
  output logic                 ram_extend_type,
  output logic [3:0]           ram_sel,
  output logic [ADDR_BITS-3:0] ram_addr,
  output logic [31:0]          ram_data_in,
  input  logic [31:0]          ram_data_out,
  output logic [CNT_BITS-1:0]  load_count,
  output logic [CNT_BITS-1:0]  store_count,
  output logic [CNT_BITS-1:0]  misalign_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LDATA = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]         r_rdata;
  logic [CNT_BITS-1:0] r_ld_cnt;
  logic [CNT_BITS-1:0] r_st_cnt;
  logic [CNT_BITS-1:0] r_mis_cnt;

  logic w_idle;
  logic w_misalign;
  logic w_access;
  logic w_store;
  logic w_unused_addr;

  // Requests are only examined in IDLE; the DONE cycle ignores mem_en.
  assign w_idle     = (r_state == S_IDLE);
  assign w_misalign = mem_en & w_idle &
                      ((mem_size == 2'd3) ||
                       ((mem_size == 2'd1) && mem_addr[0]) ||
                       ((mem_size == 2'd2) && (mem_addr[1:0] != 2'b00)));
  assign w_access   = mem_en & w_idle & ~w_misalign;
  assign w_store    = w_access & mem_we;

  // Address bits above the RAM size wrap and are intentionally dropped.
  assign w_unused_addr = ^mem_addr[31:ADDR_BITS];

  assign misalign       = w_misalign;
  assign mem_rdata      = r_rdata;
  assign load_count     = r_ld_cnt;
  assign store_count    = r_st_cnt;
  assign misalign_count = r_mis_cnt;

  // State register; reset aborts any load in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state plus RAM-side decode; RAM outputs stay quiet unless a legal request is accepted.
  always_comb begin
    w_next          = r_state;
    ram_rw          = 1'b0;
    ram_extend_type = 1'b0;
    ram_sel         = 4'b0000;
    ram_addr        = '0;
    ram_data_in     = 32'h0;
    mem_stall       = 1'b0;
    mem_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          ram_addr        = mem_addr[ADDR_BITS-1:2];
          ram_extend_type = mem_signed & (mem_size != 2'd2);
          ram_rw          = mem_we;
          case (mem_size)
            2'd0: begin
              ram_sel     = 4'b0001 << mem_addr[1:0];
              ram_data_in = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
              ram_sel     = mem_addr[1] ? 4'b1100 : 4'b0011;
              ram_data_in = {2{mem_wdata[15:0]}};
            end
            default: begin
              ram_sel     = 4'b1111;
              ram_data_in = mem_wdata;
            end
          endcase
          if (!mem_we) begin
            mem_stall = 1'b1;
            w_next    = S_LDATA;
          end
        end
      end
      S_LDATA: begin
        mem_stall = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE: begin
        mem_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the RAM's registered read data at the end of LDATA and hold it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_rdata <= 32'h0;
    else if (r_state == S_LDATA) r_rdata <= ram_data_out;
  end

  // Event counters; load is counted in LDATA so at most one bumps per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_cnt  <= '0;
      r_st_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (r_state == S_LDATA) r_ld_cnt  <= r_ld_cnt + CNT_BITS'(1);
      if (w_store)            r_st_cnt  <= r_st_cnt + CNT_BITS'(1);
      if (w_misalign)         r_mis_cnt <= r_mis_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table vectors, directed multi-cycle sequences
// and randomized requests against a byte-array reference model.
module tb_mem_access_unit;
  localparam int AB = 12;
  localparam int CB = 4;
  localparam int WA = AB - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en, mem_we, mem_signed;
  logic [1:0]    mem_size;
  logic [31:0]   mem_addr, mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_done, mem_stall, misalign;
  logic          ram_rw, ram_extend_type;
  logic [3:0]    ram_sel;
  logic [WA-1:0] ram_addr;
  logic [31:0]   ram_data_in, ram_data_out;
  logic [CB-1:0] load_count, store_count, misalign_count;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(AB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we),
    .mem_size(mem_size), .mem_signed(mem_signed), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_stall(mem_stall), .misalign(misalign), .ram_rw(ram_rw),
    .ram_extend_type(ram_extend_type), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .load_count(load_count), .store_count(store_count),
    .misalign_count(misalign_count)
  );

  // Data RAM with registered, extended read
  logic [31:0] ram [0:(1<<WA)-1];

  function automatic logic [31:0] ram_extract(logic [31:0] w, logic [3:0] s, logic e);
    logic [31:0] r;
    case (s)
      4'b0001: r = {{24{e & w[7]}},  w[7:0]};
      4'b0010: r = {{24{e & w[15]}}, w[15:8]};
      4'b0100: r = {{24{e & w[23]}}, w[23:16]};
      4'b1000: r = {{24{e & w[31]}}, w[31:24]};
      4'b0011: r = {{16{e & w[15]}}, w[15:0]};
      4'b1100: r = {{16{e & w[31]}}, w[31:16]};
      default: r = w;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_sel != 4'b0000) begin
      if (ram_rw) begin
        for (int i = 0; i < 4; i++)
          if (ram_sel[i]) ram[ram_addr][8*i +: 8] <= ram_data_in[8*i +: 8];
      end else begin
        ram_data_out <= ram_extract(ram[ram_addr], ram_sel, ram_extend_type);
      end
    end
  end

  // Reference model: flat byte memory and plain event counts
  logic [7:0] mb [0:(1<<AB)-1];
  int m_ld, m_st, m_mis;
  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit m_bad(logic [1:0] sz, logic [31:0] ad);
    if (sz == 2'd3) return 1'b1;
    return (ad % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] m_load(logic [1:0] sz, bit sg, logic [31:0] ad);
    int n = 1 << sz;
    int a = int'(ad % (32'd1 << AB));
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[a+k]) << (8*k));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_load_count"},     32'(load_count),     32'(m_ld  % (1 << CB)));
    chk({tag, "_store_count"},    32'(store_count),    32'(m_st  % (1 << CB)));
    chk({tag, "_misalign_count"}, 32'(misalign_count), 32'(m_mis % (1 << CB)));
  endtask

  // Issue one request from IDLE (called #1 after a rising edge) and see it through.
  task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] ad, input logic [31:0] wd);
    bit bad;
    int n;
    logic [3:0] msk;
    logic [31:0] din, exp_rd;
    mem_en = 1'b1; mem_we = we; mem_size = sz; mem_signed = sg;
    mem_addr = ad; mem_wdata = wd;
    #1;
    bad = m_bad(sz, ad);
    n   = 1 << sz;
    msk = 4'(((1 << n) - 1) << ad[1:0]);
    for (int i = 0; i < 4; i++) din[8*i +: 8] = wd[8*(i % n) +: 8];
    chk("misalign", 32'(misalign), 32'(bad));
    chk("stall_T", 32'(mem_stall), 32'(!bad && !we));
    chk("ram_rw", 32'(ram_rw), 32'(!bad && we));
    chk("ram_sel", 32'(ram_sel), bad ? 32'h0 : 32'(msk));
    if (!bad) begin
      chk("ram_addr", 32'(ram_addr), (ad % (32'd1 << AB)) / 4);
      chk("ram_ext", 32'(ram_extend_type), 32'(sg && sz != 2'd2));
      if (we) chk("ram_data_in", ram_data_in, din);
    end
    @(posedge clk); #1;
    if (bad) begin
      m_mis++;
      mem_en = 1'b0;
    end else if (we) begin
      for (int k = 0; k < n; k++) mb[int'(ad % (32'd1 << AB)) + k] = wd[8*k +: 8];
      m_st++;
      mem_en = 1'b0;
    end else begin
      chk("stall_T1", 32'(mem_stall), 32'd1);
      chk("sel_T1", 32'(ram_sel), 32'h0);
      chk("done_T1", 32'(mem_done), 32'd0);
      exp_rd = m_load(sz, sg, ad);
      @(posedge clk); #1;
      m_ld++;
      chk("done_T2", 32'(mem_done), 32'd1);
      chk("stall_T2", 32'(mem_stall), 32'd0);
      chk("rdata_T2", mem_rdata, exp_rd);
      chk("sel_T2", 32'(ram_sel), 32'h0);
      mem_en = 1'b0;
      @(posedge clk); #1;
      chk("done_T3", 32'(mem_done), 32'd0);
      chk("rdata_hold", mem_rdata, exp_rd);
    end
    chk_counts("req");
  endtask

  task automatic do_reset();
    mem_en = 1'b0;
    rst = 1'b0;
    m_ld = 0; m_st = 0; m_mis = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [3:0]  e_sel;
    logic [31:0] e_din;
    bit          e_mis;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << WA); i++) ram[i] = 32'h0;
    for (int i = 0; i < (1 << AB); i++) mb[i] = 8'h0;
    mem_en = 0; mem_we = 0; mem_size = 0; mem_signed = 0;
    mem_addr = 0; mem_wdata = 0;
    rst = 1'b0;
    m_ld = 0; m_st = 0; m_mis = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state with no request
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_done", 32'(mem_done), 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_sel", 32'(ram_sel), 32'h0);
    chk("rst_rw", 32'(ram_rw), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_din", ram_data_in, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk_counts("rst");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", 32'(mem_stall), 32'd0);

    //            we  sz    sg  addr          wdata         sel      din           mis
    tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 4'b1111, 32'h11223344, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 1'b0, 32'h6,    32'h0000ABCD, 4'b1100, 32'hABCDABCD, 1'b0};
    tbl[2] = '{1'b0, 2'd2, 1'b0, 32'h2,    32'h0,        4'b0000, 32'h0,        1'b1};
    tbl[3] = '{1'b0, 2'd3, 1'b0, 32'h0,    32'h0,        4'b0000, 32'h0,        1'b1};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 32'h5,    32'h000000A7, 4'b0010, 32'hA7A7A7A7, 1'b0};
    tbl[5] = '{1'b0, 2'd1, 1'b1, 32'h6,    32'h0,        4'b1100, 32'h0,        1'b0};
    tbl[6] = '{1'b1, 2'd1, 1'b0, 32'h3,    32'h1234,     4'b0000, 32'h0,        1'b1};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 32'h100B, 32'h12345655, 4'b1000, 32'h55555555, 1'b0};
    tbl[8] = '{1'b1, 2'd2, 1'b1, 32'hFFFF0020, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b0};

    for (int i = 0; i < 9; i++) begin
      mem_en = 1'b1; mem_we = tbl[i].we; mem_size = tbl[i].sz;
      mem_signed = tbl[i].sg; mem_addr = tbl[i].ad; mem_wdata = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d_sel", i), 32'(ram_sel), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_din", i), ram_data_in, tbl[i].e_din);
      chk($sformatf("tbl%0d_mis", i), 32'(misalign), 32'(tbl[i].e_mis));
      do_req(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].ad, tbl[i].wd);
    end
    chk("tbl_store_count", 32'(store_count), 32'd5);
    chk("tbl_mis_count", 32'(misalign_count), 32'd3);
    chk("ram_word1", ram[1], 32'hABCD0000 | {24'h0, 8'h00} | 32'h0000A700);

    // Signed and unsigned byte load of a preloaded word
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF0000);
    do_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
    chk("lb_rdata", mem_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
    chk("lbu_rdata", mem_rdata, 32'h00000080);

    // Reset while the load sits in LDATA
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_signed = 1'b0;
    mem_addr = 32'h10;
    @(posedge clk); #1;
    chk("abort_stall_before", 32'(mem_stall), 32'd1);
    mem_en = 1'b0;
    rst = 1'b0;
    m_ld = 0; m_st = 0; m_mis = 0;
    #1;
    chk("abort_stall", 32'(mem_stall), 32'd0);
    chk("abort_done", 32'(mem_done), 32'd0);
    chk("abort_rdata", mem_rdata, 32'h0);
    chk_counts("abort");
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(mem_done), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_after_done", 32'(mem_done), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("fresh_load", mem_rdata, 32'h11223344);

    // Store counter wrap
    do_reset();
    for (int i = 0; i < 15; i++) do_req(1'b1, 2'd2, 1'b0, 32'h400 + 32'(4*i), 32'(i));
    chk("store_count_max", 32'(store_count), 32'd15);
    do_req(1'b1, 2'd2, 1'b0, 32'h500, 32'h5A5A5A5A);
    chk("store_count_wrap", 32'(store_count), 32'd0);

    // Randomized requests against the model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      logic [1:0]  rs;
      ra = $urandom;
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << (rs == 2'd3 ? 0 : rs)) - 32'd1);
      do_req(1'($urandom), rs, 1'($urandom), ra, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
